// File: rtl/lsm_normal_accum_if.sv
// ---------------------------------------------------------------------------
// lsm_normal_accum_if
// Bundle for the normal-equation accumulator. It carries two streams:
//   - the sample stream from the path-payoff pipeline
//     (valid_in / ready_out, x_in, y_in, itm_in, last_in)
//   - the result stream to the linear solver
//     (valid_out / ready_in, sum_xx, sum_xy, n_used, n_total, sat_out)
// Modport master is the environment, which drives samples and the solver's
// ready. Modport slave is the accumulator.
// ---------------------------------------------------------------------------
interface lsm_normal_accum_if #(
  parameter int WIDTH     = 32,
  parameter int DEGREE    = 2,
  parameter int ACC_WIDTH = 64,
  parameter int CNT_WIDTH = 16
);
  logic                              valid_in;
  logic                              ready_out;
  logic signed [WIDTH-1:0]           x_in;
  logic signed [WIDTH-1:0]           y_in;
  logic                              itm_in;
  logic                              last_in;
  logic                              valid_out;
  logic                              ready_in;
  logic [2*DEGREE:0][ACC_WIDTH-1:0]  sum_xx;
  logic [DEGREE:0][ACC_WIDTH-1:0]    sum_xy;
  logic [CNT_WIDTH-1:0]              n_used;
  logic [CNT_WIDTH-1:0]              n_total;
  logic                              sat_out;

  modport master (
    output valid_in, x_in, y_in, itm_in, last_in, ready_in,
    input  ready_out, valid_out, sum_xx, sum_xy, n_used, n_total, sat_out
  );

  modport slave (
    input  valid_in, x_in, y_in, itm_in, last_in, ready_in,
    output ready_out, valid_out, sum_xx, sum_xy, n_used, n_total, sat_out
  );
endinterface

// File: rtl/lsm_normal_accum.sv
// ---------------------------------------------------------------------------
// lsm_normal_accum
// Builds the normal-equation power sums for the Longstaff-Schwartz regression.
// For each in-the-money sample it accumulates:
//   - sum x^k   for k = 0..2*DEGREE
//   - sum y*x^k for k = 0..DEGREE
// All values are in Q(WIDTH-QFRAC).QFRAC. At the end of a batch it holds the
// sums for the solver until the valid/ready handshake completes.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   acc_if  slave side of lsm_normal_accum_if (sample in, sums out)
// ---------------------------------------------------------------------------
module lsm_normal_accum #(
  parameter int WIDTH     = 32,
  parameter int QFRAC     = 16,
  parameter int DEGREE    = 2,
  parameter int ACC_WIDTH = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lsm_normal_accum_if.slave    acc_if
);
  localparam int NP = 2 * DEGREE;  // highest power needed
  localparam int NS = NP;          // power-chain stages; stage s holds x^(s+1)
  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic signed [ACC_WIDTH-1:0] ONE_ACC =
    {{(ACC_WIDTH-QFRAC-1){1'b0}}, 1'b1, {QFRAC{1'b0}}};

  typedef logic signed [WIDTH-1:0]     word_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  // Q multiply with floor (>>>) and saturation to WIDTH; MSB = saturated.
  function automatic logic [WIDTH:0] q_mul(input word_t a, input word_t b);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shr;
    prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    shr  = prod >>> QFRAC;
    if (shr[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){shr[WIDTH-1]}})
      q_mul = {1'b0, shr[WIDTH-1:0]};
    else if (shr[2*WIDTH-1])
      q_mul = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else
      q_mul = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Saturating signed accumulate; MSB = saturated.
  function automatic logic [ACC_WIDTH:0] acc_add(input acc_t a, input acc_t b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] == s[ACC_WIDTH-1])
      acc_add = {1'b0, s[ACC_WIDTH-1:0]};
    else if (s[ACC_WIDTH])
      acc_add = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      acc_add = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  function automatic acc_t sext(input word_t v);
    sext = {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Control state
  logic [1:0]           state_q, state_d;
  logic                 ready_q, ready_d, valid_q, valid_d, sat_q, sat_d;
  logic                 done_q, clear_c, accept;
  logic [CNT_WIDTH-1:0] n_used_q, n_used_d, n_total_q, n_total_d;
  acc_t                 acc_xx_q [NP+1];
  acc_t                 acc_xx_d [NP+1];
  acc_t                 acc_xy_q [DEGREE+1];
  acc_t                 acc_xy_d [DEGREE+1];

  // Power-chain pipeline (data, no reset) with its enables (reset)
  word_t                pw_p   [NS][NP];
  word_t                yx_p   [NS][DEGREE+1];
  logic                 psat_p [NS];
  logic                 en_p   [NS];
  logic                 last_p [NS];
  logic [WIDTH:0]       pmul_c [NS-1];
  logic [WIDTH:0]       ymul_c [DEGREE];
  logic                 psat_c [NS-1];
  acc_t                 txx_pt [NP];
  acc_t                 txy_pt [DEGREE+1];
  logic                 sat_pt, en_pt, last_pt;
  logic [ACC_WIDTH:0]   addxx_c [NP+1];
  logic [ACC_WIDTH:0]   addxy_c [DEGREE+1];

  assign accept = acc_if.valid_in && ready_q;

  always_comb begin
    for (int s = 1; s < NS; s++) begin
      pmul_c[s-1] = q_mul(pw_p[s-1][s-1], pw_p[s-1][0]);
      psat_c[s-1] = psat_p[s-1] | pmul_c[s-1][WIDTH];
    end
    for (int s = 1; s <= DEGREE; s++) begin
      ymul_c[s-1] = q_mul(yx_p[s-1][0], pw_p[s-1][s-1]);
      psat_c[s-1] = psat_c[s-1] | ymul_c[s-1][WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    // Stage 0: capture sample; x^1 and y*x^0 are the raw inputs
    for (int k = 0; k < NP; k++)
      pw_p[0][k] <= (k == 0) ? acc_if.x_in : '0;
    for (int k = 0; k <= DEGREE; k++)
      yx_p[0][k] <= (k == 0) ? acc_if.y_in : '0;
    psat_p[0] <= 1'b0;
    // Stages 1..NS-1: one new power per stage, y*x^s joins at stage s
    for (int s = 1; s < NS; s++) begin
      for (int k = 0; k < NP; k++)
        pw_p[s][k] <= pw_p[s-1][k];
      for (int k = 0; k <= DEGREE; k++)
        yx_p[s][k] <= yx_p[s-1][k];
      pw_p[s][s] <= pmul_c[s-1][WIDTH-1:0];
      psat_p[s]  <= psat_c[s-1];
    end
    for (int s = 1; s <= DEGREE; s++)
      yx_p[s][s] <= ymul_c[s-1][WIDTH-1:0];
    // Term stage: registered sign extension ahead of the wide adders
    for (int k = 0; k < NP; k++)
      txx_pt[k] <= sext(pw_p[NS-1][k]);
    for (int k = 0; k <= DEGREE; k++)
      txy_pt[k] <= sext(yx_p[NS-1][k]);
    sat_pt <= psat_p[NS-1];
  end

  always_comb begin
    addxx_c[0] = acc_add(acc_xx_q[0], ONE_ACC);
    for (int k = 1; k <= NP; k++)
      addxx_c[k] = acc_add(acc_xx_q[k], txx_pt[k-1]);
    for (int k = 0; k <= DEGREE; k++)
      addxy_c[k] = acc_add(acc_xy_q[k], txy_pt[k]);
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    clear_c   = 1'b0;
    sat_d     = sat_q;
    n_used_d  = n_used_q;
    n_total_d = n_total_q;
    acc_xx_d  = acc_xx_q;
    acc_xy_d  = acc_xy_q;
    case (state_q)
      ACCUM: begin
        ready_d = 1'b1;
        if (accept && acc_if.last_in) begin
          state_d = DRAIN;
          ready_d = 1'b0;
        end
      end
      DRAIN: if (done_q) begin
        state_d = HOLD;
        valid_d = 1'b1;
      end
      HOLD: if (acc_if.ready_in) begin
        state_d = ACCUM;
        valid_d = 1'b0;
        ready_d = 1'b1;
        clear_c = 1'b1;
      end
      default: begin
        state_d = ACCUM;
        ready_d = 1'b0;
      end
    endcase
    // Masked samples never reach here, so they cannot touch sat_out
    if (en_pt) begin
      sat_d = sat_d | sat_pt;
      for (int k = 0; k <= NP; k++) begin
        acc_xx_d[k] = addxx_c[k][ACC_WIDTH-1:0];
        sat_d       = sat_d | addxx_c[k][ACC_WIDTH];
      end
      for (int k = 0; k <= DEGREE; k++) begin
        acc_xy_d[k] = addxy_c[k][ACC_WIDTH-1:0];
        sat_d       = sat_d | addxy_c[k][ACC_WIDTH];
      end
    end
    if (accept) begin
      if (n_total_q != '1) n_total_d = n_total_q + CNT_WIDTH'(1);
      if (acc_if.itm_in && (n_used_q != '1)) n_used_d = n_used_q + CNT_WIDTH'(1);
    end
    if (clear_c) begin
      sat_d     = 1'b0;
      n_used_d  = '0;
      n_total_d = '0;
      for (int k = 0; k <= NP; k++) acc_xx_d[k] = '0;
      for (int k = 0; k <= DEGREE; k++) acc_xy_d[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      en_pt     <= 1'b0;
      last_pt   <= 1'b0;
      n_used_q  <= '0;
      n_total_q <= '0;
      for (int s = 0; s < NS; s++) begin
        en_p[s]   <= 1'b0;
        last_p[s] <= 1'b0;
      end
      for (int k = 0; k <= NP; k++) acc_xx_q[k] <= '0;
      for (int k = 0; k <= DEGREE; k++) acc_xy_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      n_used_q  <= n_used_d;
      n_total_q <= n_total_d;
      acc_xx_q  <= acc_xx_d;
      acc_xy_q  <= acc_xy_d;
      en_p[0]   <= accept & acc_if.itm_in;
      last_p[0] <= accept & acc_if.last_in;
      for (int s = 1; s < NS; s++) begin
        en_p[s]   <= en_p[s-1];
        last_p[s] <= last_p[s-1];
      end
      en_pt   <= en_p[NS-1];
      last_pt <= last_p[NS-1];
      // done_q marks the edge on which the batch's last sample was accumulated
      done_q  <= last_pt;
    end
  end

  for (genvar k = 0; k <= NP; k++) begin : g_xx
    assign acc_if.sum_xx[k] = acc_xx_q[k];
  end
  for (genvar k = 0; k <= DEGREE; k++) begin : g_xy
    assign acc_if.sum_xy[k] = acc_xy_q[k];
  end
  assign acc_if.ready_out = ready_q;
  assign acc_if.valid_out = valid_q;
  assign acc_if.n_used    = n_used_q;
  assign acc_if.n_total   = n_total_q;
  assign acc_if.sat_out   = sat_q;
endmodule
